scaler_v_ctrl: RTL and testbench
================================

SCALER_V_CTRL -- requirements
Module: scaler_v_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, pixel data width.
REQ-002 SHALL have parameter LINE_IN_SIZE_MAX, default 1024, pixel-counter saturation value.
REQ-003 SHALL have parameter LINE_SIZE_DEFAULT, default 255, line_in_size reset value.
REQ-004 SHALL have parameter SCALE_STEP_DEFAULT, default 8192, scale_step reset value (2.0 at step 4096).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_scale_step  in  16  new scale step
- cfg_wr  in  1  one-cycle strobe; captures cfg_scale_step into pending register
- err_clr  in  1  clears err_width
- di_i  in  PIXEL_WIDTH  raw pixel
- de_i  in  1  raw pixel valid
- hs_i  in  1  level; high = horizontal blanking
- vs_i  in  1  level; high = active frame
- do_o  out  PIXEL_WIDTH  pixel to scaler
- de_o  out  1  pixel valid to scaler
- hs_o  out  1  one-cycle line-start pulse
- vs_o  out  1  one-cycle frame-start pulse, coincident with first hs_o of frame
- line_in_size  out  16  line width for scaler
- scale_step  out  16  active scale step for scaler
- fr_cnt  out  8  frames started, wraps 255->0
- err_width  out  1  sticky: line width mismatch within a frame

Function
REQ-006 SHALL register hs_i, vs_i each cycle; rise/fall edges SHALL be detected against the registered copies.
REQ-007 SHALL implement FSM WAIT_VS, WAIT_LINE, IN_LINE; reset state WAIT_VS.
REQ-008 WAIT_VS: exit to WAIT_LINE on vs_i rising edge, setting first_line flag; all hs_i edges ignored.
REQ-009 WAIT_LINE: on hs_i falling edge with vs_i=1 go IN_LINE, clear pixel counter, assert hs_o next cycle; also assert vs_o that cycle if first_line is set.
REQ-010 IN_LINE: count de_i=1 cycles, saturating at LINE_IN_SIZE_MAX; on hs_i rising edge go WAIT_LINE and evaluate width (REQ-013).
REQ-011 Any state: vs_i falling edge SHALL return FSM to WAIT_VS; an open line SHALL be dropped without width evaluation; de_o SHALL be forced 0 from the cycle after the edge.
REQ-012 do_o/de_o SHALL equal di_i/de_i delayed exactly 1 cycle while in WAIT_LINE or IN_LINE; de_o=0 in WAIT_VS; do_o SHALL hold last value when de_o=0.
REQ-013 Width: at end of first line of frame, store count in meas_size and set meas_valid; at end of later lines, count != meas_size SHALL set err_width.
REQ-014 At each vs_o cycle: line_in_size <= meas_size if meas_valid (then clear meas_valid), else unchanged; scale_step <= pending if pending_valid (then clear); fr_cnt increments.
REQ-015 cfg_wr in the same cycle as vs_o SHALL load scale_step directly with cfg_scale_step and leave pending_valid clear; otherwise cfg_wr updates pending, last write wins.
REQ-016 err_clr SHALL clear err_width; err_clr and a mismatch in the same cycle SHALL leave err_width=1.
REQ-017 line_in_size and scale_step SHALL never change except in a vs_o cycle.

Reset
REQ-018 On rst: FSM=WAIT_VS; do_o=0, de_o=0, hs_o=0, vs_o=0, fr_cnt=0, err_width=0, line_in_size=LINE_SIZE_DEFAULT, scale_step=SCALE_STEP_DEFAULT; pending_valid, meas_valid, first_line, counter cleared.
REQ-019 Reset released mid-frame SHALL produce no hs_o/vs_o/de_o until the next vs_i rising edge.

Verification
REQ-020 Reset, then 2 frames of 16 lines x 24 pixels, DE every cycle -> frame 1: vs_o with first hs_o, 16 hs_o, line_in_size=255; frame 2: line_in_size=24, fr_cnt=2, err_width=0.
REQ-021 cfg_wr step=4096 mid-frame 1 -> scale_step stays 8192 until frame 2 vs_o, then 4096; cfg_wr coincident with vs_o -> value applied in that cycle.
REQ-022 Frame with line 5 carrying 23 pixels -> err_width=1 from line 5 end; err_clr -> 0; err_clr coincident with new mismatch -> stays 1.
REQ-023 vs_i falls in mid-line 3 -> de_o=0 next cycle, no further hs_o, FSM in WAIT_VS, meas from line 1 retained.
REQ-024 DE_I period 4 (1 valid per 4 cycles), 24 pixels/line -> de_o pattern identical with 1-cycle lag, measured width 24; 2000-pixel line -> width saturates at 1024.
REQ-025 rst asserted for 3 cycles mid-line of frame 1 -> all outputs at REQ-018 values, no pulses until next vs_i rise, fr_cnt=1 after that frame start.

Source files
------------

// File: rtl/scaler_v_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_v_ctrl
//
// Input-side timing controller for the vertical scaler. It tracks the raw
// video timing (vs_i frame level, hs_i blanking level, de_i pixel strobe),
// forwards pixels to the scaler with a fixed one-cycle latency, produces
// single-cycle line-start / frame-start pulses, measures the active line
// width and flags width changes inside a frame. The scaler configuration
// (line width and scale step) only changes at frame start, so the scaler
// never sees a parameter change mid-frame.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous, active-high reset
//   cfg_scale_step  new scale step, captured on cfg_wr
//   cfg_wr          one-cycle write strobe for cfg_scale_step
//   err_clr         clears the sticky err_width flag
//   di_i / de_i     raw pixel and pixel valid
//   hs_i            horizontal blanking level (high = blanking)
//   vs_i            frame level (high = active frame)
//   do_o / de_o     pixel and valid to the scaler (1-cycle latency)
//   hs_o            one-cycle line-start pulse
//   vs_o            one-cycle frame-start pulse, coincident with first hs_o
//   line_in_size    line width handed to the scaler
//   scale_step      active scale step handed to the scaler
//   fr_cnt          number of frames started, wraps at 8 bits
//   err_width       sticky flag: line width differed from first line of frame
// -----------------------------------------------------------------------------
module scaler_v_ctrl #(
  parameter int PIXEL_WIDTH        = 8,
  parameter int LINE_IN_SIZE_MAX   = 1024,
  parameter int LINE_SIZE_DEFAULT  = 255,
  parameter int SCALE_STEP_DEFAULT = 8192
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cfg_scale_step,
  input  logic                   cfg_wr,
  input  logic                   err_clr,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic [15:0]            line_in_size,
  output logic [15:0]            scale_step,
  output logic [7:0]             fr_cnt,
  output logic                   err_width
);

  localparam logic [15:0] CNT_MAX      = 16'(LINE_IN_SIZE_MAX);
  localparam logic [15:0] SIZE_DEFAULT = 16'(LINE_SIZE_DEFAULT);
  localparam logic [15:0] STEP_DEFAULT = 16'(SCALE_STEP_DEFAULT);

  typedef enum logic [1:0] {
    WAIT_VS   = 2'd0,
    WAIT_LINE = 2'd1,
    IN_LINE   = 2'd2
  } state_t;

  // Saturating pixel-count increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v >= CNT_MAX) begin
      return CNT_MAX;
    end
    return v + 16'd1;
  endfunction

  state_t                   r_state;
  logic                     r_hs_p1;
  logic                     r_vs_p1;
  logic [15:0]              r_cnt;
  logic                     r_first_line;
  logic                     r_line_first;
  logic                     r_hs_o;
  logic                     r_vs_o;
  logic [PIXEL_WIDTH-1:0]   r_do;
  logic                     r_de;
  logic [15:0]              r_meas_size;
  logic                     r_meas_valid;
  logic [15:0]              r_pending;
  logic                     r_pending_valid;
  logic [15:0]              r_line_in_size;
  logic [15:0]              r_scale_step;
  logic [7:0]               r_fr_cnt;
  logic                     r_err_width;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_hs_rise;
  logic w_hs_fall;
  logic w_line_end;
  logic w_mismatch;

  assign w_vs_rise  = vs_i & ~r_vs_p1;
  assign w_vs_fall  = ~vs_i & r_vs_p1;
  assign w_hs_rise  = hs_i & ~r_hs_p1;
  assign w_hs_fall  = ~hs_i & r_hs_p1;

  // A line closes on the start of horizontal blanking, unless the frame is
  // aborted in the same cycle; an aborted line is never width-checked.
  assign w_line_end = (r_state == IN_LINE) & w_hs_rise & ~w_vs_fall;
  assign w_mismatch = w_line_end & ~r_line_first & (r_cnt != r_meas_size);

  // ---- stage p1: registered copies of the timing levels ----
  // They come out of reset high so that a vs_i already high when reset is
  // released does not look like a frame start; the controller then waits
  // for a genuine vs_i rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_p1 <= 1'b1;
      r_vs_p1 <= 1'b1;
    end else begin
      r_hs_p1 <= hs_i;
      r_vs_p1 <= vs_i;
    end
  end

  // ---- timing FSM, line counter and start pulses ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_VS;
      r_cnt        <= 16'd0;
      r_first_line <= 1'b0;
      r_line_first <= 1'b0;
      r_hs_o       <= 1'b0;
      r_vs_o       <= 1'b0;
    end else begin
      r_hs_o <= 1'b0;
      r_vs_o <= 1'b0;
      if (w_vs_fall) begin
        // Frame aborted or ended: drop whatever line is open.
        r_state <= WAIT_VS;
      end else begin
        case (r_state)
          WAIT_VS: begin
            if (w_vs_rise) begin
              r_state      <= WAIT_LINE;
              r_first_line <= 1'b1;
            end
          end
          WAIT_LINE: begin
            if (w_hs_fall && vs_i) begin
              r_state      <= IN_LINE;
              r_cnt        <= 16'd0;
              r_hs_o       <= 1'b1;
              r_vs_o       <= r_first_line;
              r_line_first <= r_first_line;
              r_first_line <= 1'b0;
            end
          end
          IN_LINE: begin
            if (w_hs_rise) begin
              r_state <= WAIT_LINE;
            end else if (de_i) begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
          default: r_state <= WAIT_VS;
        endcase
      end
    end
  end

  // ---- stage p1: pixel forwarding ----
  // do_o only loads on a valid pixel so it holds the last pixel between
  // strobes; de_o is suppressed outside a frame and from the cycle after
  // a frame abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_do <= '0;
      r_de <= 1'b0;
    end else begin
      if ((r_state != WAIT_VS) && !w_vs_fall) begin
        r_de <= de_i;
        if (de_i) begin
          r_do <= di_i;
        end
      end else begin
        r_de <= 1'b0;
      end
    end
  end

  // ---- width measurement, configuration shadowing and frame counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas_size     <= 16'd0;
      r_meas_valid    <= 1'b0;
      r_pending       <= 16'd0;
      r_pending_valid <= 1'b0;
      r_line_in_size  <= SIZE_DEFAULT;
      r_scale_step    <= STEP_DEFAULT;
      r_fr_cnt        <= 8'd0;
      r_err_width     <= 1'b0;
    end else begin
      // Frame start: publish the shadowed values to the scaler. A write
      // landing exactly on the frame-start cycle bypasses the shadow.
      if (r_vs_o) begin
        r_fr_cnt <= r_fr_cnt + 8'd1;
        if (r_meas_valid) begin
          r_line_in_size <= r_meas_size;
          r_meas_valid   <= 1'b0;
        end
        if (cfg_wr) begin
          r_scale_step    <= cfg_scale_step;
          r_pending_valid <= 1'b0;
        end else if (r_pending_valid) begin
          r_scale_step    <= r_pending;
          r_pending_valid <= 1'b0;
        end
      end else if (cfg_wr) begin
        r_pending       <= cfg_scale_step;
        r_pending_valid <= 1'b1;
      end

      // The first line of a frame defines the reference width. Placed after
      // the frame-start block so a fresh measurement is never lost.
      if (w_line_end && r_line_first) begin
        r_meas_size  <= r_cnt;
        r_meas_valid <= 1'b1;
      end

      // A new mismatch wins over a simultaneous clear.
      if (w_mismatch) begin
        r_err_width <= 1'b1;
      end else if (err_clr) begin
        r_err_width <= 1'b0;
      end
    end
  end

  assign do_o         = r_do;
  assign de_o         = r_de;
  assign hs_o         = r_hs_o;
  assign vs_o         = r_vs_o;
  assign line_in_size = r_line_in_size;
  assign scale_step   = r_scale_step;
  assign fr_cnt       = r_fr_cnt;
  assign err_width    = r_err_width;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scaler_v_ctrl
//
// Drives whole frames of video timing with randomized pixel data, pixel gaps
// and blanking lengths. A frame-level reference model (expected pixel queue,
// per-frame pulse counts, shadowed configuration and width bookkeeping)
// supplies every expected value.
// -----------------------------------------------------------------------------
module tb_scaler_v_ctrl;

  localparam int PW   = 8;
  localparam int LMAX = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cfg_scale_step;
  logic          cfg_wr;
  logic          err_clr;
  logic [PW-1:0] di_i;
  logic          de_i;
  logic          hs_i;
  logic          vs_i;
  logic [PW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;
  logic [15:0]   line_in_size;
  logic [15:0]   scale_step;
  logic [7:0]    fr_cnt;
  logic          err_width;

  scaler_v_ctrl #(
    .PIXEL_WIDTH       (PW),
    .LINE_IN_SIZE_MAX  (LMAX),
    .LINE_SIZE_DEFAULT (255),
    .SCALE_STEP_DEFAULT(8192)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_scale_step(cfg_scale_step),
    .cfg_wr        (cfg_wr),
    .err_clr       (err_clr),
    .di_i          (di_i),
    .de_i          (de_i),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .do_o          (do_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .line_in_size  (line_in_size),
    .scale_step    (scale_step),
    .fr_cnt        (fr_cnt),
    .err_width     (err_width)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int q_pix[$];
  int q_cyc[$];
  int m_lis, m_step, m_pend, m_meas, m_fr;
  bit m_pend_v, m_meas_v, m_err, m_live;

  function automatic void model_reset();
    m_lis    = 255;
    m_step   = 8192;
    m_pend   = 0;
    m_pend_v = 0;
    m_meas   = 0;
    m_meas_v = 0;
    m_fr     = 0;
    m_err    = 0;
    m_live   = 0;
  endfunction

  function automatic void model_frame_start(input bit cfg_vs, input int v);
    if (m_meas_v) begin
      m_lis    = m_meas;
      m_meas_v = 0;
    end
    if (cfg_vs) begin
      m_step   = v;
      m_pend_v = 0;
    end else if (m_pend_v) begin
      m_step   = m_pend;
      m_pend_v = 0;
    end
    m_fr = (m_fr + 1) % 256;
  endfunction

  function automatic void model_line_end(input int npix, input bit first, input bit clr);
    int c;
    c = (npix > LMAX) ? LMAX : npix;
    if (clr) m_err = 0;
    if (first) begin
      m_meas   = c;
      m_meas_v = 1;
    end else if (c != m_meas) begin
      m_err = 1;
    end
  endfunction

  // ---------------- output monitor ----------------
  int          hs_cnt = 0;
  int          vs_cnt = 0;
  logic        prev_vs_o = 1'b0;
  logic        prev_rst  = 1'b1;
  logic [15:0] prev_lis  = '0;
  logic [15:0] prev_ss   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (de_o) begin
        if (q_pix.size() == 0) begin
          chk("de_o_spurious", de_o, 0);
        end else begin
          chk("do_o", do_o, q_pix.pop_front());
          chk("de_o_lag", cyc, q_cyc.pop_front());
        end
      end
      if (hs_o) hs_cnt++;
      if (vs_o) begin
        vs_cnt++;
        chk("vs_o_with_hs_o", hs_o, 1);
      end
      if (!prev_rst && (line_in_size !== prev_lis || scale_step !== prev_ss))
        chk("cfg_change_outside_vs", prev_vs_o, 1);
    end
    prev_vs_o = vs_o;
    prev_rst  = rst;
    prev_lis  = line_in_size;
    prev_ss   = scale_step;
  end

  // ---------------- checks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_do_o"}, do_o, 0);
    chk({tag, "_de_o"}, de_o, 0);
    chk({tag, "_hs_o"}, hs_o, 0);
    chk({tag, "_vs_o"}, vs_o, 0);
    chk({tag, "_fr_cnt"}, fr_cnt, 0);
    chk({tag, "_err_width"}, err_width, 0);
    chk({tag, "_line_in_size"}, line_in_size, 255);
    chk({tag, "_scale_step"}, scale_step, 8192);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_line_in_size"}, line_in_size, m_lis);
    chk({tag, "_scale_step"}, scale_step, m_step);
    chk({tag, "_fr_cnt"}, fr_cnt, m_fr);
    chk({tag, "_err_width"}, err_width, m_err);
  endtask

  task automatic do_err_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err   = 0;
    step();
    chk("err_clr", err_width, m_err);
  endtask

  // ---------------- stimulus ----------------
  // One line: hs_i falls, an idle cycle (the frame-start cycle on a first
  // line), npix pixels with gaps, then horizontal blanking.
  task automatic drive_line(input int npix, input int period, input bit first,
                            input bit cfg_vs, input logic [15:0] cfg_val,
                            input bit clr_end, input int drop_at, input int rst_at);
    int gap;
    hs_i = 1'b0;
    de_i = 1'b0;
    step();
    if (first && m_live) model_frame_start(cfg_vs, int'(cfg_val));
    if (first && cfg_vs) begin
      cfg_scale_step = cfg_val;
      cfg_wr         = 1'b1;
    end
    step();
    cfg_wr = 1'b0;
    for (int p = 0; p < npix; p++) begin
      if (drop_at > 0 && p == drop_at) begin
        // vs_i falls while a pixel is still offered: it must not reach de_o
        vs_i   = 1'b0;
        de_i   = 1'b1;
        di_i   = PW'($urandom);
        m_live = 0;
        step();
        repeat (3) begin
          di_i = PW'($urandom);
          step();
        end
        de_i = 1'b0;
        hs_i = 1'b1;
        step();
        hs_i = 1'b0;
        step();
        hs_i = 1'b1;
        step();
        step();
        return;
      end
      if (rst_at > 0 && p == rst_at) begin
        de_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) step();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        model_reset();
        hs_i = 1'b1;
        repeat (3) step();
        return;
      end
      di_i = PW'($urandom);
      de_i = 1'b1;
      if (m_live) begin
        q_pix.push_back(int'(di_i));
        q_cyc.push_back(cyc + 1);
      end
      step();
      de_i = 1'b0;
      gap = (period > 0) ? period - 1 : int'($urandom_range(0, 2));
      repeat (gap) step();
    end
    hs_i = 1'b1;
    de_i = 1'b0;
    if (clr_end) err_clr = 1'b1;
    if (m_live) model_line_end(npix, first, clr_end);
    else if (clr_end) m_err = 0;
    step();
    err_clr = 1'b0;
    repeat ($urandom_range(2, 4)) step();
    chk("err_width_line", err_width, m_err);
  endtask

  // cfg_mode: 0 none, 1 two writes after line 2 (last wins), 2 write in the vs_o cycle
  task automatic drive_frame(input string tag, input int nlines, input int npix,
                             input int period, input int short_line, input int short_pix,
                             input int drop_line, input int rst_line, input int cfg_mode,
                             input logic [15:0] cfg_val, input int clr_line);
    int n;
    int exp_hs;
    int exp_vs;
    hs_cnt = 0;
    vs_cnt = 0;
    exp_hs = 0;
    hs_i   = 1'b1;
    de_i   = 1'b0;
    vs_i   = 1'b1;
    m_live = 1;
    exp_vs = 1;
    repeat (3) step();
    for (int l = 1; l <= nlines; l++) begin
      n = (l == short_line) ? short_pix : npix;
      if (m_live) exp_hs++;
      drive_line(n, period, l == 1, cfg_mode == 2, cfg_val, l == clr_line,
                 (l == drop_line) ? 3 : 0, (l == rst_line) ? n / 2 : 0);
      if (l == drop_line) break;
      if (cfg_mode == 1 && l == 2) begin
        cfg_scale_step = 16'($urandom);
        cfg_wr         = 1'b1;
        step();
        cfg_scale_step = cfg_val;
        step();
        cfg_wr   = 1'b0;
        m_pend   = int'(cfg_val);
        m_pend_v = 1;
        step();
        chk({tag, "_step_mid"}, scale_step, m_step);
      end
    end
    vs_i = 1'b0;
    hs_i = 1'b1;
    de_i = 1'b0;
    m_live = 0;
    repeat (4) step();
    chk({tag, "_hs_count"}, hs_cnt, exp_hs);
    chk({tag, "_vs_count"}, vs_cnt, exp_vs);
    check_regs(tag);
  endtask

  initial begin
    int nl, np, sl;
    rst            = 1'b1;
    cfg_scale_step = 16'd0;
    cfg_wr         = 1'b0;
    err_clr        = 1'b0;
    di_i           = '0;
    de_i           = 1'b0;
    hs_i           = 1'b1;
    vs_i           = 1'b0;
    model_reset();
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) step();
    check_regs("idle");

    // two nominal frames, step write in the middle of frame 1
    drive_frame("f1", 16, 24, 1, 0, 0, 0, 0, 1, 16'd4096, 0);
    drive_frame("f2", 16, 24, 1, 0, 0, 0, 0, 0, 16'd0, 0);
    // sparse DE, write coincident with frame start
    drive_frame("f3", 6, 24, 4, 0, 0, 0, 0, 2, 16'($urandom), 0);
    // width error on line 5, then clear
    drive_frame("f4", 6, 24, 1, 5, 23, 0, 0, 0, 16'd0, 0);
    do_err_clr();
    // clear coincident with a new mismatch
    drive_frame("f5", 6, 24, 0, 5, 23, 0, 0, 0, 16'd0, 5);
    do_err_clr();
    // frame aborted mid line 3; first-line width must survive
    np = int'($urandom_range(8, 30));
    drive_frame("f6", 8, np, 0, 0, 0, 3, 0, 0, 16'd0, 0);
    drive_frame("f7", 4, int'($urandom_range(5, 30)), 0, 0, 0, 0, 0, 0, 16'd0, 0);
    // saturating width
    drive_frame("f8", 2, 2000, 1, 0, 0, 0, 0, 0, 16'd0, 0);
    drive_frame("f9", 2, 10, 1, 0, 0, 0, 0, 0, 16'd0, 0);
    do_err_clr();
    // randomized frames
    for (int k = 0; k < 3; k++) begin
      nl = int'($urandom_range(2, 5));
      np = int'($urandom_range(1, 40));
      sl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, nl)) : 0;
      drive_frame("rnd", nl, np, int'($urandom_range(0, 3)), sl, np + 1, 0, 0,
                  int'($urandom_range(0, 2)), 16'($urandom), 0);
    end
    do_err_clr();
    // reset in the middle of line 2, then one full frame
    drive_frame("rst_frame", 4, 20, 1, 0, 0, 0, 2, 0, 16'd0, 0);
    drive_frame("after_rst", 3, 12, 1, 0, 0, 0, 0, 0, 16'd0, 0);
    chk("after_rst_fr_cnt", fr_cnt, 1);

    repeat (3) step();
    chk("pixels_left", q_pix.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
